// File: rtl/jpeg_mcu_scheduler.sv
// jpeg_mcu_scheduler: sequences decoded 8x8 coefficient blocks toward dequant/IDCT,
// tagging each with component, quant table, block-in-MCU index and MCU position.
// Optional feature: define JPEG_RESTART_EN to stall at restart-interval boundaries.
module jpeg_mcu_scheduler #(
    parameter int DIM_W = 16,
    parameter int RST_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_scan,
    input  logic [DIM_W-1:0] img_width,
    input  logic [DIM_W-1:0] img_height,
    input  logic [2:0]       h_samp0,
    input  logic [2:0]       v_samp0,
    input  logic [1:0]       quant_id0,
    input  logic [1:0]       quant_id1,
    input  logic [1:0]       quant_id2,
    input  logic             blk_in_valid,
    output logic             blk_in_ready,
    output logic             blk_out_valid,
    input  logic             blk_out_ready,
    output logic [1:0]       comp_idx,
    output logic [1:0]       q_sel,
    output logic [2:0]       blk_in_mcu,
    output logic [DIM_W-1:0] mcu_x,
    output logic [DIM_W-1:0] mcu_y,
    output logic             busy,
    output logic             frame_done
`ifdef JPEG_RESTART_EN
    ,
    input  logic [RST_W-1:0] restart_interval,
    output logic             rst_sync_req,
    input  logic             rst_sync_ack
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_RUN,
`ifdef JPEG_RESTART_EN
        S_RST_WAIT,
`endif
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        M_444,
        M_422,
        M_420
    } mode_t;

    state_t           state_q, state_d;
    mode_t            mode_q;
    logic [DIM_W-1:0] width_q, height_q;
    logic [1:0]       qid0_q, qid1_q, qid2_q;
    logic [DIM_W-1:0] mcus_x_q, mcus_y_q;
    logic [1:0]       comp_q, qsel_q;
    logic [2:0]       blk_q;
    logic [DIM_W-1:0] mx_q, my_q;

    logic [2:0]       last_blk_idx, num_y_blks, nxt_blk;
    logic [1:0]       nxt_comp, nxt_qsel;
    logic             xfer, blk_last, x_last, y_last, frame_last, dims_zero;
    logic [DIM_W-1:0] mcus_x_calc, mcus_y_calc;

`ifdef JPEG_RESTART_EN
    logic [RST_W-1:0] mcu_cnt_q;
    logic             interval_hit;
`endif

    // ceil(v / 2^s) for the MCU sizes in use (8 or 16 pixels)
    function automatic logic [DIM_W-1:0] ceil_div(input logic [DIM_W-1:0] v, input logic by16);
        if (by16) ceil_div = DIM_W'(({1'b0, v} + (DIM_W+1)'(15)) >> 4);
        else      ceil_div = DIM_W'(({1'b0, v} + (DIM_W+1)'(7)) >> 3);
    endfunction

    // MCU geometry, handshake gating and next-tag derivation
    always_comb begin
        last_blk_idx = 3'd2;
        num_y_blks   = 3'd1;
        case (mode_q)
            M_420: begin last_blk_idx = 3'd5; num_y_blks = 3'd4; end
            M_422: begin last_blk_idx = 3'd3; num_y_blks = 3'd2; end
            default: ;
        endcase

        mcus_x_calc = ceil_div(width_q, mode_q != M_444);
        mcus_y_calc = ceil_div(height_q, mode_q == M_420);
        dims_zero   = (width_q == '0) || (height_q == '0);

        blk_in_ready  = blk_out_ready & (state_q == S_RUN) & ~start_scan;
        blk_out_valid = blk_in_valid & (state_q == S_RUN);
        xfer          = blk_in_valid & blk_in_ready;

        blk_last   = (blk_q == last_blk_idx);
        x_last     = (mx_q == mcus_x_q - DIM_W'(1));
        y_last     = (my_q == mcus_y_q - DIM_W'(1));
        frame_last = blk_last & x_last & y_last;

        nxt_blk  = blk_last ? 3'd0 : blk_q + 3'd1;
        nxt_comp = (nxt_blk < num_y_blks) ? 2'd0 : 2'(nxt_blk - num_y_blks + 3'd1);
        case (nxt_comp)
            2'd0:    nxt_qsel = qid0_q;
            2'd1:    nxt_qsel = qid1_q;
            default: nxt_qsel = qid2_q;
        endcase

`ifdef JPEG_RESTART_EN
        interval_hit = (restart_interval != '0) && (mcu_cnt_q + RST_W'(1) == restart_interval);
        rst_sync_req = (state_q == S_RST_WAIT);
`endif
    end

    // next-state logic; start_scan overrides whatever state is current
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: ;
            S_CALC: state_d = dims_zero ? S_DONE : S_RUN;
            S_RUN: begin
                if (xfer && frame_last) state_d = S_DONE;
`ifdef JPEG_RESTART_EN
                else if (xfer && blk_last && interval_hit) state_d = S_RST_WAIT;
            end
            S_RST_WAIT: begin
                if (rst_sync_ack) state_d = S_RUN;
`endif
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (start_scan) state_d = S_CALC;
    end

    // state, latched configuration, MCU counts and block tags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mode_q   <= M_444;
            width_q  <= '0;
            height_q <= '0;
            qid0_q   <= '0;
            qid1_q   <= '0;
            qid2_q   <= '0;
            mcus_x_q <= '0;
            mcus_y_q <= '0;
            comp_q   <= '0;
            qsel_q   <= '0;
            blk_q    <= '0;
            mx_q     <= '0;
            my_q     <= '0;
`ifdef JPEG_RESTART_EN
            mcu_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (start_scan) begin
                if (h_samp0 == 3'd2 && v_samp0 == 3'd2)      mode_q <= M_420;
                else if (h_samp0 == 3'd2 && v_samp0 == 3'd1) mode_q <= M_422;
                else                                         mode_q <= M_444;
                width_q  <= img_width;
                height_q <= img_height;
                qid0_q   <= quant_id0;
                qid1_q   <= quant_id1;
                qid2_q   <= quant_id2;
                comp_q   <= '0;
                qsel_q   <= '0;
                blk_q    <= '0;
                mx_q     <= '0;
                my_q     <= '0;
`ifdef JPEG_RESTART_EN
                mcu_cnt_q <= '0;
`endif
            end else if (state_q == S_CALC) begin
                mcus_x_q <= mcus_x_calc;
                mcus_y_q <= mcus_y_calc;
                // q_sel of block 0 is loaded here so it is valid on the first RUN cycle
                qsel_q   <= dims_zero ? 2'd0 : qid0_q;
            end else if (state_q == S_DONE) begin
                comp_q <= '0;
                qsel_q <= '0;
                blk_q  <= '0;
                mx_q   <= '0;
                my_q   <= '0;
            end else if (state_q == S_RUN && xfer && !frame_last) begin
                blk_q  <= nxt_blk;
                comp_q <= nxt_comp;
                qsel_q <= nxt_qsel;
                if (blk_last) begin
                    if (x_last) begin
                        mx_q <= '0;
                        my_q <= my_q + DIM_W'(1);
                    end else begin
                        mx_q <= mx_q + DIM_W'(1);
                    end
`ifdef JPEG_RESTART_EN
                    mcu_cnt_q <= mcu_cnt_q + RST_W'(1);
`endif
                end
            end
`ifdef JPEG_RESTART_EN
            else if (state_q == S_RST_WAIT && rst_sync_ack) begin
                mcu_cnt_q <= '0;
            end
`endif
        end
    end

    assign comp_idx   = comp_q;
    assign q_sel      = qsel_q;
    assign blk_in_mcu = blk_q;
    assign mcu_x      = mx_q;
    assign mcu_y      = my_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_DONE);

endmodule
